// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with registered read, programmable almost-full/almost-empty,
// sticky overflow/underflow flags and a synchronous flush.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  w_inc,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_inc,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]         wptr_reg, rptr_reg;
  logic [DATA_WIDTH-1:0] r_data_reg;
  logic                  r_valid_reg;
  logic                  overflow_reg, underflow_reg;

  logic [PW-1:0]         count_next;
  logic                  wr_accept, rd_accept;

  // Status is decoded from the registered pointers only, so request inputs
  // never reach the flags combinationally.
  assign count_next   = wptr_reg - rptr_reg;
  assign count        = count_next;
  assign full         = (count_next == PW'(DEPTH));
  assign empty        = (count_next == '0);
  assign almost_full  = (count_next >= PW'(AF_LEVEL));
  assign almost_empty = (count_next <= PW'(AE_LEVEL));

  assign wr_accept = w_inc && !full  && !flush;
  assign rd_accept = r_inc && !empty && !flush;

  assign r_data    = r_data_reg;
  assign r_valid   = r_valid_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

  // Storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept)
      mem[wptr_reg[ADDR_WIDTH-1:0]] <= w_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      r_data_reg    <= '0;
      r_valid_reg   <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (flush) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      r_valid_reg   <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      r_valid_reg <= rd_accept;
      if (wr_accept)
        wptr_reg <= wptr_reg + 1'b1;
      if (rd_accept) begin
        r_data_reg <= mem[rptr_reg[ADDR_WIDTH-1:0]];
        rptr_reg   <= rptr_reg + 1'b1;
      end
      if (w_inc && full)
        overflow_reg <= 1'b1;
      if (r_inc && empty)
        underflow_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed and randomized checks of sync_fifo_ctrl against a queue-based model.
module tb_sync_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, w_inc, r_inc;
  logic [DW-1:0] w_data;
  logic [DW-1:0] r_data;
  logic          r_valid, full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  sync_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .w_inc(w_inc), .w_data(w_data),
    .r_inc(r_inc), .r_data(r_data), .r_valid(r_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, plus the observable registers.
  bit [DW-1:0] q[$];
  logic [DW-1:0] exp_rdata;
  logic exp_rv, exp_ov, exp_uv;

  int tests = 0;
  int fails = 0;
  int step_no = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s step %0d: got %0h expected %0h", tag, step_no, obs, expv);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("count",        32'(count),        32'(n));
    check("full",         32'(full),         32'(n == DEPTH));
    check("empty",        32'(empty),        32'(n == 0));
    check("almost_full",  32'(almost_full),  32'(n >= AF));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE));
    check("overflow",     32'(overflow),     32'(exp_ov));
    check("underflow",    32'(underflow),    32'(exp_uv));
    check("r_valid",      32'(r_valid),      32'(exp_rv));
    check("r_data",       32'(r_data),       32'(exp_rdata));
  endtask

  task automatic model_reset();
    q.delete();
    exp_rdata = '0;
    exp_rv = 1'b0;
    exp_ov = 1'b0;
    exp_uv = 1'b0;
  endtask

  // One clock cycle: drive, advance past the edge, update model, compare.
  task automatic step(input logic w, input logic [DW-1:0] wd, input logic r, input logic fl);
    bit was_full, was_empty;
    w_inc = w; w_data = wd; r_inc = r; flush = fl;
    @(posedge clk);
    #1;
    step_no++;
    if (fl) begin
      q.delete();
      exp_ov = 1'b0;
      exp_uv = 1'b0;
      exp_rv = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      exp_rv = r && !was_empty;
      if (r && !was_empty) exp_rdata = q.pop_front();
      if (w && !was_full)  q.push_back(wd);
      if (w && was_full)   exp_ov = 1'b1;
      if (r && was_empty)  exp_uv = 1'b1;
    end
    check_all();
    $display("[TB] step %0d w=%0b wd=%02h r=%0b fl=%0b cnt=%0d rv=%0b rd=%02h ov=%0b uv=%0b",
             step_no, w, wd, r, fl, count, r_valid, r_data, overflow, underflow);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; w_inc = 1'b0; r_inc = 1'b0; w_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Fill with 0x11..0x18, then drain.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Full with simultaneous write and read: read wins, write dropped.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Empty with simultaneous write and read: no fall-through.
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Streaming across the pointer wrap at constant occupancy.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset between edges mid-burst.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    w_inc = 1'b0; r_inc = 1'b0; flush = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    $display("[TB] async reset asserted cnt=%0d rv=%0b", count, r_valid);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic with phases biased toward filling and draining.
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = ((i / 40) % 2 == 0) ? 80 : 25;
      step(1'b0 || ($urandom_range(99) < wp), 8'($urandom), ($urandom_range(99) < 100 - wp),
           ($urandom_range(99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
